// File: rtl/pixel_writer.sv
// Pixel writer: buffers arbitrated render pixels in a small FIFO and streams them to the
// framebuffer write port, with a full-frame clear sweep that takes priority over pixel writes.
module pixel_writer #(
    parameter int unsigned FB_DEPTH    = 38400,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pixel_valid_in,
    input  logic [15:0] pixel_addr_in,
    input  logic [15:0] pixel_color_in,
    output logic        pixel_ready_out,
    input  logic        frame_clear_in,
    output logic        clearing_out,
    output logic        fb_we_out,
    output logic [15:0] fb_addr_out,
    output logic [15:0] fb_data_out,
    output logic [15:0] drop_count_out
);

    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [16:0] FbLimit  = 17'(FB_DEPTH);
    localparam logic [15:0] LastAddr = 16'(FB_DEPTH - 1);

    typedef enum logic [0:0] {StRun, StClear} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [15:0]     clr_cnt_q, clr_cnt_d;
    logic            fb_we_q, fb_we_d;
    logic [15:0]     fb_addr_q, fb_addr_d;
    logic [15:0]     fb_data_q, fb_data_d;
    logic [15:0]     drop_q, drop_d;
    logic            clearing_q, clearing_d;
    logic            push, pop;
    logic [15:0]     pop_addr, pop_color;

    // Ready depends only on the registered count, so a pop never frees a slot the same cycle.
    assign pixel_ready_out = (count_q != FifoFull);
    assign push            = pixel_valid_in && pixel_ready_out;
    assign pop             = (state_q == StRun) && (count_q != '0) && !frame_clear_in;
    assign {pop_addr, pop_color} = fifo_mem[rd_ptr_q];

    assign clearing_out   = clearing_q;
    assign fb_we_out      = fb_we_q;
    assign fb_addr_out    = fb_addr_q;
    assign fb_data_out    = fb_data_q;
    assign drop_count_out = drop_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pixel_addr_in, pixel_color_in};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        drop_d    = drop_q;
        unique case (state_q)
            StRun: begin
                if (frame_clear_in) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end else if (pop) begin
                    if ({1'b0, pop_addr} < FbLimit) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = pop_addr;
                        fb_data_d = pop_color;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            StClear: begin
                // A repeated request restarts the sweep; that edge writes nothing.
                if (frame_clear_in) begin
                    clr_cnt_d = '0;
                end else begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = clr_cnt_q;
                    fb_data_d = CLEAR_COLOR;
                    clr_cnt_d = clr_cnt_q + 16'd1;
                    if (clr_cnt_q == LastAddr) begin
                        state_d = StRun;
                    end
                end
            end
        endcase
        clearing_d = (state_d == StClear);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StRun;
            clr_cnt_q  <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            drop_q     <= '0;
            clearing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            drop_q     <= drop_d;
            clearing_q <= clearing_d;
        end
    end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 38400, number of framebuffer words (addresses 0..FB_DEPTH-1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, pixel FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CLEAR_COLOR, default 16'h0000, word written during frame clear.
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pixel_valid_in  input  1  arbitrated render pixel present.
REQ-007 SHALL have port pixel_addr_in  input  16  framebuffer address of pixel.
REQ-008 SHALL have port pixel_color_in  input  16  pixel color.
REQ-009 SHALL have port pixel_ready_out  output  1  writer accepts a pixel this cycle.
REQ-010 SHALL have port frame_clear_in  input  1  single-cycle request to clear the framebuffer.
REQ-011 SHALL have port clearing_out  output  1  high while in CLEAR state.
REQ-012 SHALL have port fb_we_out  output  1  framebuffer write enable.
REQ-013 SHALL have port fb_addr_out  output  16  framebuffer write address.
REQ-014 SHALL have port fb_data_out  output  16  framebuffer write data.
REQ-015 SHALL have port drop_count_out  output  16  saturating count of discarded out-of-range pixels.

Function
REQ-016 SHALL accept a pixel when pixel_valid_in && pixel_ready_out at a rising edge, pushing {addr,color} into the FIFO.
REQ-017 SHALL drive pixel_ready_out = !fifo_full, combinationally from registered FIFO count; no push when full even if a pop occurs that cycle.
REQ-018 SHALL implement two states, RUN and CLEAR; RUN after reset.
REQ-019 SHALL, in RUN with FIFO non-empty, pop one entry per cycle and on the next edge register fb_we_out=1, fb_addr_out=addr, fb_data_out=color if addr < FB_DEPTH.
REQ-020 SHALL, for a popped entry with addr >= FB_DEPTH, drive fb_we_out=0 and increment drop_count_out, saturating at 16'hFFFF.
REQ-021 SHALL give latency of exactly one cycle from acceptance to fb_we_out when FIFO empty and state RUN (push and pop of the same entry forbidden same cycle; entry popped the cycle after push).
REQ-022 SHALL preserve acceptance order on fb writes; no pixel lost except out-of-range drops.
REQ-023 SHALL transition RUN->CLEAR on the edge where frame_clear_in=1, loading clear counter to 0.
REQ-024 SHALL, in CLEAR, register fb_we_out=1, fb_addr_out=counter, fb_data_out=CLEAR_COLOR each cycle, counter incrementing by 1.
REQ-025 SHALL transition CLEAR->RUN on the edge after writing address FB_DEPTH-1; exactly FB_DEPTH clear writes per clear.
REQ-026 SHALL restart the counter at 0 if frame_clear_in=1 during CLEAR (clear restarts, state stays CLEAR).
REQ-027 SHALL keep accepting pixels into the FIFO during CLEAR (ready = !full) and not pop during CLEAR.
REQ-028 SHALL drive fb_we_out=0 in RUN when FIFO empty; fb_addr_out/fb_data_out hold last value.
REQ-029 SHALL register all fb_* outputs, clearing_out, and drop_count_out.

Reset
REQ-030 SHALL, on rst_in=0 asynchronously: state=RUN, FIFO empty, counter=0, fb_we_out=0, fb_addr_out=0, fb_data_out=0, clearing_out=0, drop_count_out=0, pixel_ready_out=1.
REQ-031 SHALL abort any clear or pending FIFO contents on reset mid-operation; no fb write on the first edge after release.

Verification
REQ-032 SHALL test: single pixel addr=16'h0010 color=16'hF800 at cycle N, FIFO empty -> fb_we_out=1, addr 16'h0010, data 16'hF800 at cycle N+1, single cycle.
REQ-033 SHALL test: burst of 12 pixels with FIFO_DEPTH=8 and frame_clear_in asserted first -> ready drops after 8 accepts; after FB_DEPTH clear writes all 12 written in order.
REQ-034 SHALL test: FB_DEPTH=16, frame_clear_in pulse -> 16 writes of CLEAR_COLOR to addresses 0..15, clearing_out high exactly 16 cycles.
REQ-035 SHALL test: pixel addr=FB_DEPTH -> fb_we_out stays 0, drop_count_out increments 0->1; forced 65536 drops -> holds 16'hFFFF.
REQ-036 SHALL test: frame_clear_in again at counter=5 -> next write address 0, total clear length 6+FB_DEPTH cycles.
REQ-037 SHALL test: rst_in low mid-clear with 3 FIFO entries -> outputs immediately to reset values; no writes after release until new input.
